// File: rtl/multicycle_control_unit_if.sv
// Handshake and strobe bundle between the multi-cycle controller
// and its environment (instruction/data memory, IR, datapath).
interface multicycle_control_unit_if #(
    parameter int OP_W     = 5,
    parameter int ALU_OP_W = 2
);
    logic [OP_W-1:0]     op;
    logic                imem_ready;
    logic                dmem_ready;
    logic                trap_ack;
    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                dmem_req;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_write;
    logic [ALU_OP_W-1:0] alu_op;
    logic                trap;
    logic [1:0]          trap_cause;
    logic [2:0]          state;

    modport master (
        input  op, imem_ready, dmem_ready, trap_ack,
        output imem_req, ir_write, pc_write, branch,
        output mem_read, mem_write, dmem_req, mem_to_reg,
        output alu_src, reg_write, alu_op,
        output trap, trap_cause, state
    );

    modport slave (
        output op, imem_ready, dmem_ready, trap_ack,
        input  imem_req, ir_write, pc_write, branch,
        input  mem_read, mem_write, dmem_req, mem_to_reg,
        input  alu_src, reg_write, alu_op,
        input  trap, trap_cause, state
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 main controller: FETCH/DECODE/EXEC/MEM/WB
// sequencing with memory-ready handshakes and trap on fault.
module multicycle_control_unit #(
    parameter int OP_W     = 5,
    parameter int ALU_OP_W = 2,
    parameter int TIMEOUT  = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst,
    multicycle_control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_LOAD  = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_STORE = OP_W'(5'b01000);
    localparam logic [OP_W-1:0] OP_BR    = OP_W'(5'b11000);
    localparam logic [OP_W-1:0] OP_ARI   = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_ARR   = OP_W'(5'b01100);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
    localparam bit               TO_EN   = (TIMEOUT != 0);

    state_t            st;
    logic [OP_W-1:0]   op_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic [1:0]        cause;

    logic legal;
    logic to_hit;
    logic is_load;
    logic is_store;
    logic is_br;
    logic is_ari;
    logic is_arr;

    // Opcode classification: live op for DECODE, latched op_q afterwards
    always_comb begin
        legal    = (bus.op == OP_LOAD) || (bus.op == OP_STORE) ||
                   (bus.op == OP_BR)   || (bus.op == OP_ARI)   ||
                   (bus.op == OP_ARR);
        to_hit   = TO_EN && (wait_cnt == CNT_TO);
        is_load  = (op_q == OP_LOAD);
        is_store = (op_q == OP_STORE);
        is_br    = (op_q == OP_BR);
        is_ari   = (op_q == OP_ARI);
        is_arr   = (op_q == OP_ARR);
    end

    // State, latched opcode, wait counter and trap cause
    always_ff @(posedge clk) begin
        if (rst) begin
            st       <= S_FETCH;
            op_q     <= '0;
            wait_cnt <= '0;
            cause    <= 2'b00;
        end else begin
            case (st)
                S_FETCH: begin
                    if (bus.imem_ready) begin
                        st       <= S_DECODE;
                        wait_cnt <= '0;
                    end else if (to_hit) begin
                        st       <= S_TRAP;
                        cause    <= 2'b10;
                        wait_cnt <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_DECODE: begin
                    op_q     <= bus.op;
                    wait_cnt <= '0;
                    if (legal) begin
                        st <= S_EXEC;
                    end else begin
                        st    <= S_TRAP;
                        cause <= 2'b01;
                    end
                end
                S_EXEC: begin
                    wait_cnt <= '0;
                    if (is_br)
                        st <= S_FETCH;
                    else if (is_load || is_store)
                        st <= S_MEM;
                    else
                        st <= S_WB;
                end
                S_MEM: begin
                    if (bus.dmem_ready) begin
                        st       <= is_load ? S_WB : S_FETCH;
                        wait_cnt <= '0;
                    end else if (to_hit) begin
                        st       <= S_TRAP;
                        cause    <= 2'b11;
                        wait_cnt <= '0;
                    end else if (wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_WB: begin
                    st       <= S_FETCH;
                    wait_cnt <= '0;
                end
                S_TRAP: begin
                    wait_cnt <= '0;
                    if (bus.trap_ack) begin
                        st    <= S_FETCH;
                        cause <= 2'b00;
                    end
                end
                default: begin
                    st       <= S_FETCH;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    logic                imem_req;
    logic                ir_write;
    logic                pc_write;
    logic                branch;
    logic                mem_read;
    logic                mem_write;
    logic                dmem_req;
    logic                mem_to_reg;
    logic                alu_src;
    logic                reg_write;
    logic [ALU_OP_W-1:0] alu_op;

    // Per-state strobes; IR/PC pulses qualified by the memory ready
    always_comb begin
        imem_req   = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        dmem_req   = 1'b0;
        mem_to_reg = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = '0;
        case (st)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = bus.imem_ready;
            end
            S_EXEC: begin
                alu_src = is_load || is_store || is_ari;
                if (is_br) begin
                    alu_op   = ALU_OP_W'(2'b01);
                    branch   = 1'b1;
                    pc_write = 1'b1;
                end else if (is_arr) begin
                    alu_op = ALU_OP_W'(2'b10);
                end else if (is_ari) begin
                    alu_op = ALU_OP_W'(2'b11);
                end
            end
            S_MEM: begin
                dmem_req  = 1'b1;
                alu_src   = 1'b1;
                mem_read  = is_load;
                mem_write = is_store;
                pc_write  = is_store && bus.dmem_ready;
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                mem_to_reg = is_load;
            end
            default: ;
        endcase
    end

    assign bus.imem_req   = imem_req;
    assign bus.ir_write   = ir_write;
    assign bus.pc_write   = pc_write;
    assign bus.branch     = branch;
    assign bus.mem_read   = mem_read;
    assign bus.mem_write  = mem_write;
    assign bus.dmem_req   = dmem_req;
    assign bus.mem_to_reg = mem_to_reg;
    assign bus.alu_src    = alu_src;
    assign bus.reg_write  = reg_write;
    assign bus.alu_op     = alu_op;
    assign bus.trap       = (st == S_TRAP);
    assign bus.trap_cause = cause;
    assign bus.state      = st;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: stimulus pushes the
// expected per-cycle outputs, a negedge monitor pops and compares.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.OP_W(5), .ALU_OP_W(2)) bus();

    multicycle_control_unit #(
        .OP_W(5), .ALU_OP_W(2), .TIMEOUT(15), .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // flags: imem_req ir_write pc_write branch mem_read
    //        mem_write dmem_req mem_to_reg alu_src reg_write
    typedef struct packed {
        logic [2:0] st;
        logic [9:0] f;
        logic [1:0] aop;
        logic       trp;
        logic [1:0] cause;
    } exp_t;

    typedef struct {
        string nm;
        exp_t  e;
    } item_t;

    localparam logic [4:0] LD  = 5'b00000;
    localparam logic [4:0] ST  = 5'b01000;
    localparam logic [4:0] BR  = 5'b11000;
    localparam logic [4:0] AI  = 5'b00100;
    localparam logic [4:0] AR  = 5'b01100;
    localparam logic [4:0] BAD = 5'b11111;

    localparam logic [9:0] F_NONE  = 10'b0000000000;
    localparam logic [9:0] F_REQ   = 10'b1000000000;
    localparam logic [9:0] F_IRW   = 10'b1100000000;
    localparam logic [9:0] F_ASRC  = 10'b0000000010;
    localparam logic [9:0] F_BR    = 10'b0011000000;
    localparam logic [9:0] F_LDMEM = 10'b0000101010;
    localparam logic [9:0] F_STMEM = 10'b0000011010;
    localparam logic [9:0] F_STDON = 10'b0010011010;
    localparam logic [9:0] F_WB    = 10'b0010000001;
    localparam logic [9:0] F_WBLD  = 10'b0010000101;

    item_t sb[$];
    int    tests = 0;
    int    fails = 0;

    function automatic exp_t mk(input logic [2:0] s, input logic [9:0] f,
                                input logic [1:0] a, input logic t,
                                input logic [1:0] c);
        exp_t e;
        e.st    = s;
        e.f     = f;
        e.aop   = a;
        e.trp   = t;
        e.cause = c;
        return e;
    endfunction

    // Drive one cycle of inputs and queue the outputs expected in it
    task automatic step(input string nm, input logic [4:0] o,
                        input logic ir, input logic dr,
                        input logic ack, input logic r, input exp_t e);
        item_t it;
        bus.op         = o;
        bus.imem_ready = ir;
        bus.dmem_ready = dr;
        bus.trap_ack   = ack;
        rst            = r;
        it.nm = nm;
        it.e  = e;
        sb.push_back(it);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare DUT outputs against the queue head mid-cycle
    always @(negedge clk) begin
        item_t it;
        exp_t  a;
        if (sb.size() != 0) begin
            it = sb.pop_front();
            a  = {bus.state,
                  bus.imem_req, bus.ir_write, bus.pc_write, bus.branch,
                  bus.mem_read, bus.mem_write, bus.dmem_req,
                  bus.mem_to_reg, bus.alu_src, bus.reg_write,
                  bus.alu_op, bus.trap, bus.trap_cause};
            tests++;
            if (a !== it.e) begin
                fails++;
                $display("FAIL %s: got %h want %h", it.nm, a, it.e);
            end
        end
    end

    initial begin
        rst            = 1'b1;
        bus.op         = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.trap_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        step("rst_state", AR, 0, 0, 0, 0, mk(0, F_REQ, 0, 0, 0));

        step("ar_fetch", AR, 1, 1, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("ar_dec", AR, 1, 1, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("ar_exec", AR, 1, 1, 0, 0, mk(2, F_NONE, 2'b10, 0, 0));
        step("ar_wb", AR, 1, 1, 0, 0, mk(4, F_WB, 0, 0, 0));

        step("ld_fetch", LD, 1, 0, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("ld_dec", LD, 1, 0, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("ld_exec", LD, 1, 0, 0, 0, mk(2, F_ASRC, 0, 0, 0));
        for (int i = 0; i < 3; i++)
            step("ld_mem_wait", LD, 1, 0, 0, 0, mk(3, F_LDMEM, 0, 0, 0));
        step("ld_mem_rdy", LD, 1, 1, 0, 0, mk(3, F_LDMEM, 0, 0, 0));
        step("ld_wb", LD, 1, 0, 0, 0, mk(4, F_WBLD, 0, 0, 0));

        step("st_fetch", ST, 1, 1, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("st_dec", ST, 1, 1, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("st_exec", ST, 1, 1, 0, 0, mk(2, F_ASRC, 0, 0, 0));
        step("st_mem", ST, 1, 1, 0, 0, mk(3, F_STDON, 0, 0, 0));

        step("br_fetch", BR, 1, 1, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("br_dec", BR, 1, 1, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("br_exec", BR, 1, 1, 0, 0, mk(2, F_BR, 2'b01, 0, 0));

        step("ai_fetch", AI, 1, 1, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("ai_dec", AI, 1, 1, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("ai_exec", AI, 1, 1, 0, 0, mk(2, F_ASRC, 2'b11, 0, 0));
        step("ai_wb", AI, 1, 1, 0, 0, mk(4, F_WB, 0, 0, 0));

        step("ill_fetch", BAD, 1, 1, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("ill_dec", BAD, 1, 1, 0, 0, mk(1, F_NONE, 0, 0, 0));
        for (int i = 0; i < 10; i++)
            step("ill_trap_hold", BAD, 1, 1, 0, 0, mk(5, F_NONE, 0, 1, 2'b01));
        step("ill_trap_ack", BAD, 1, 1, 1, 0, mk(5, F_NONE, 0, 1, 2'b01));
        step("ill_refetch", AR, 1, 1, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("ill_re_dec", AR, 1, 1, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("ill_re_exec", AR, 1, 1, 0, 0, mk(2, F_NONE, 2'b10, 0, 0));
        step("ill_re_wb", AR, 1, 1, 0, 0, mk(4, F_WB, 0, 0, 0));

        for (int i = 0; i < 16; i++)
            step("ito_wait", LD, 0, 0, 0, 0, mk(0, F_REQ, 0, 0, 0));
        step("ito_trap", LD, 0, 0, 0, 0, mk(5, F_NONE, 0, 1, 2'b10));
        step("ito_ack", LD, 0, 0, 1, 0, mk(5, F_NONE, 0, 1, 2'b10));
        for (int i = 0; i < 15; i++)
            step("ito_wait2", LD, 0, 0, 0, 0, mk(0, F_REQ, 0, 0, 0));
        step("ito_late_rdy", LD, 1, 0, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("ito_no_trap", LD, 0, 0, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("rst_exec", LD, 0, 0, 0, 0, mk(2, F_ASRC, 0, 0, 0));
        step("rst_mem_w", LD, 0, 0, 0, 0, mk(3, F_LDMEM, 0, 0, 0));
        step("rst_mem_r", LD, 0, 1, 0, 1, mk(3, F_LDMEM, 0, 0, 0));
        step("rst_dropreq", LD, 0, 0, 0, 0, mk(0, F_REQ, 0, 0, 0));

        step("dto_fetch", ST, 1, 0, 0, 0, mk(0, F_IRW, 0, 0, 0));
        step("dto_dec", ST, 1, 0, 0, 0, mk(1, F_NONE, 0, 0, 0));
        step("dto_exec", ST, 1, 0, 0, 0, mk(2, F_ASRC, 0, 0, 0));
        for (int i = 0; i < 16; i++)
            step("dto_wait", ST, 1, 0, 0, 0, mk(3, F_STMEM, 0, 0, 0));
        step("dto_trap", ST, 1, 0, 1, 1, mk(5, F_NONE, 0, 1, 2'b11));
        step("dto_rst", ST, 0, 0, 0, 0, mk(0, F_REQ, 0, 0, 0));

        for (int i = 0; i < 5 && sb.size() != 0; i++)
            @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
